id_ex_stage: RTL

//  ID/EX pipeline register plus operand-forwarding select; sits directly upstream of the ALU.

---
 rtl/id_ex_stage_if.sv | 53 +++++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: hazard controls, decoded ID fields, MEM/WB forward taps and EX-side outputs.
// Latency: none (wiring only).
// Backpressure: stall/flush from the hazard unit travel on this bus; there is no valid/ready pair.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // hazard unit controls
    logic                      stall;
    logic                      flush;
    // decode slot
    logic                      id_valid;
    logic [DATA_WIDTH-1:0]     id_rd1;
    logic [DATA_WIDTH-1:0]     id_rd2;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [2:0]                id_alu_control;
    logic                      id_alu_src;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_reg_write;
    // forward taps from later stages
    logic                      mem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_result;
    // EX slot towards ALU and EX/MEM
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     SRCA;
    logic [DATA_WIDTH-1:0]     SRCB;
    logic [2:0]                ALUcontrol;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;

    // decode / hazard / later-stage side
    modport master (
        output stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_alu_control, id_alu_src,
               id_rs1, id_rs2, id_rd, id_reg_write,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        input  ex_valid, SRCA, SRCB, ALUcontrol, ex_store_data, ex_rd, ex_reg_write
    );

    // the pipeline register itself
    modport slave (
        input  stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_alu_control, id_alu_src,
               id_rs1, id_rs2, id_rd, id_reg_write,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        output ex_valid, SRCA, SRCB, ALUcontrol, ex_store_data, ex_rd, ex_reg_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding (forwarding built only with ID_EX_FWD_EN).
// Latency: 1 cycle from ID inputs to EX outputs; forward muxes are combinational after the register.
// Backpressure: stall holds the slot (operands recapture forwards), flush loads a bubble and wins over stall.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int RW = REG_ADDR_WIDTH;

    logic          valid_q,     valid_d;
    logic [DW-1:0] rd1_q,       rd1_d;
    logic [DW-1:0] rd2_q,       rd2_d;
    logic [DW-1:0] imm_q,       imm_d;
    logic [2:0]    ctl_q,       ctl_d;
    logic          alu_src_q,   alu_src_d;
    logic [RW-1:0] rs1_q,       rs1_d;
    logic [RW-1:0] rs2_q,       rs2_d;
    logic [RW-1:0] rd_q,        rd_d;
    logic          reg_write_q, reg_write_d;

    logic [DW-1:0] fwd_rs1;
    logic [DW-1:0] fwd_rs2;

`ifdef ID_EX_FWD_EN
    // MEM is the younger producer, so it beats WB; x0 is hard-wired and never forwarded
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] rs,
        input logic [DW-1:0] rf_dat,
        input logic          mem_we,
        input logic [RW-1:0] mem_dst,
        input logic [DW-1:0] mem_dat,
        input logic          wb_we,
        input logic [RW-1:0] wb_dst,
        input logic [DW-1:0] wb_dat
    );
        logic [DW-1:0] r;
        r = rf_dat;
        if (rs != '0) begin
            if (mem_we && (mem_dst == rs))
                r = mem_dat;
            else if (wb_we && (wb_dst == rs))
                r = wb_dat;
        end
        return r;
    endfunction

    // per-operand forward select on the registered source indices
    always_comb begin
        fwd_rs1 = fwd_sel(rs1_q, rd1_q, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_result);
        fwd_rs2 = fwd_sel(rs2_q, rd2_q, bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    end
`else
    // without forwarding the operands are the register-file data captured at decode
    always_comb begin
        fwd_rs1 = rd1_q;
        fwd_rs2 = rd2_q;
    end

    logic unused_fwd;
    assign unused_fwd = ^{bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_result, rs1_q, rs2_q};
`endif

    // next-state: flush clears, stall holds (operands take their forwarded value), else load
    always_comb begin
        valid_d     = valid_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        ctl_d       = ctl_q;
        alu_src_d   = alu_src_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            rd1_d       = '0;
            rd2_d       = '0;
            imm_d       = '0;
            ctl_d       = '0;
            alu_src_d   = 1'b0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            reg_write_d = 1'b0;
        end else if (bus.stall) begin
            // a producer retiring from WB during the stall is folded into our copy;
            // with forwarding compiled out fwd_rs* equal rd*_q, so this is a plain hold
            rd1_d = fwd_rs1;
            rd2_d = fwd_rs2;
        end else begin
            valid_d     = bus.id_valid;
            rd1_d       = bus.id_rd1;
            rd2_d       = bus.id_rd2;
            imm_d       = bus.id_imm;
            ctl_d       = bus.id_alu_control;
            alu_src_d   = bus.id_alu_src;
            rs1_d       = bus.id_rs1;
            rs2_d       = bus.id_rs2;
            rd_d        = bus.id_rd;
            reg_write_d = bus.id_reg_write;
        end
    end

    // pipeline register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            ctl_q       <= '0;
            alu_src_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            ctl_q       <= ctl_d;
            alu_src_q   <= alu_src_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    // store data ignores alu_src; bubbles can never request a write-back
    assign bus.ex_valid      = valid_q;
    assign bus.SRCA          = fwd_rs1;
    assign bus.SRCB          = alu_src_q ? imm_q : fwd_rs2;
    assign bus.ALUcontrol    = ctl_q;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_reg_write  = reg_write_q & valid_q;
endmodule
